seg7_pattern_decoder: RTL

//   Decodes active-low 7-segment patterns (bit order [6]=g..[0]=a) back into a 4-bit digit.

---
 rtl/seg7_pattern_decoder_if.sv | 23 ++
 rtl/seg7_pattern_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_pattern_decoder_if.sv
// Display-side bus for seg7_pattern_decoder: observed segment pattern and strobe in,
// qualified digit, blank/error flags and saturating illegal-pattern count out.
interface seg7_pattern_decoder_if #(
  parameter int ERR_W = 8
);
  logic [6:0]       iSEG;
  logic             iSAMPLE;
  logic [3:0]       oDIG;
  logic             oVALID;
  logic             oBLANK;
  logic             oERR;
  logic [ERR_W-1:0] oERR_CNT;

  modport master (
    output iSEG, iSAMPLE,
    input  oDIG, oVALID, oBLANK, oERR, oERR_CNT
  );

  modport slave (
    input  iSEG, iSAMPLE,
    output oDIG, oVALID, oBLANK, oERR, oERR_CNT
  );
endinterface

// File: rtl/seg7_pattern_decoder.sv
// Decodes active-low 7-segment patterns (bit [6]=g .. [0]=a) back to a digit, accepting a
// pattern only after STABLE_CYCLES identical strobed samples; flags blanks and illegal codes.
module seg7_pattern_decoder #(
  parameter int STABLE_CYCLES = 3,
  parameter int ERR_W         = 8
) (
  input logic                   iCLK,
  input logic                   iRST,
  seg7_pattern_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {S_EMPTY, S_COUNT, S_LOCKED} state_e;
  typedef enum logic [1:0] {P_LEGAL, P_BLANK, P_ILLEGAL} pat_kind_e;

  typedef struct packed {
    pat_kind_e  kind;
    logic [3:0] digit;
  } pat_info_t;

  function automatic pat_info_t decode(input logic [6:0] seg);
    pat_info_t info;
    info.kind  = P_LEGAL;
    info.digit = 4'd0;
    unique case (seg)
      7'b1000000: info.digit = 4'd0;
      7'b1111001: info.digit = 4'd1;
      7'b0100100: info.digit = 4'd2;
      7'b0110000: info.digit = 4'd3;
      7'b0011001: info.digit = 4'd4;
      7'b0010010: info.digit = 4'd5;
      7'b0000010: info.digit = 4'd6;
      7'b1111000: info.digit = 4'd7;
      7'b0000000: info.digit = 4'd8;
      7'b0011000: info.digit = 4'd9;
      7'b1111111: info.kind  = P_BLANK;
      default:    info.kind  = P_ILLEGAL;
    endcase
    return info;
  endfunction

  state_e           state_q,   state_d;
  logic [6:0]       cand_q,    cand_d;
  logic [CW-1:0]    cnt_q,     cnt_d;
  logic [3:0]       dig_q,     dig_d;
  logic             valid_q,   valid_d;
  logic             blank_q,   blank_d;
  logic             err_q,     err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic      accept;
  pat_info_t info;

  assign info = decode(bus.iSEG);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;

    if (bus.iSAMPLE) begin
      unique case (state_q)
        S_COUNT: begin
          if (bus.iSEG == cand_q) begin
            cnt_d = cnt_q + ONE_C;
            if (cnt_q + ONE_C == STABLE_C) begin
              accept  = 1'b1;
              state_d = S_LOCKED;
            end
          end else begin
            cand_d = bus.iSEG;
            cnt_d  = ONE_C;
            if (STABLE_CYCLES == 1) begin
              accept  = 1'b1;
              state_d = S_LOCKED;
            end
          end
        end
        S_LOCKED: begin
          // A repeat of the locked pattern is silent; any change restarts qualification.
          if (bus.iSEG != cand_q) begin
            cand_d  = bus.iSEG;
            cnt_d   = ONE_C;
            state_d = S_COUNT;
            if (STABLE_CYCLES == 1) begin
              accept  = 1'b1;
              state_d = S_LOCKED;
            end
          end
        end
        default: begin
          cand_d  = bus.iSEG;
          cnt_d   = ONE_C;
          state_d = S_COUNT;
          if (STABLE_CYCLES == 1) begin
            accept  = 1'b1;
            state_d = S_LOCKED;
          end
        end
      endcase
    end

    dig_d     = dig_q;
    blank_d   = blank_q;
    err_cnt_d = err_cnt_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (accept) begin
      unique case (info.kind)
        P_LEGAL: begin
          dig_d   = info.digit;
          valid_d = 1'b1;
          blank_d = 1'b0;
        end
        P_BLANK: blank_d = 1'b1;
        default: begin
          err_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        end
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q   <= S_EMPTY;
      cand_q    <= 7'h7F;
      cnt_q     <= '0;
      dig_q     <= 4'd0;
      valid_q   <= 1'b0;
      blank_q   <= 1'b1;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      valid_q   <= valid_d;
      blank_q   <= blank_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.oDIG     = dig_q;
  assign bus.oVALID   = valid_q;
  assign bus.oBLANK   = blank_q;
  assign bus.oERR     = err_q;
  assign bus.oERR_CNT = err_cnt_q;

endmodule
